// File: rtl/set_candidate_counter.sv
// Lattice-point counter for an 8x8 grid against up to three circles.
// One job per start; the result is strobed with valid after a fixed-length scan.
module set_candidate_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] central,
  input  logic [11:0] radius,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  candidate
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] cen_q;
  logic [11:0] rad_q;
  logic [1:0]  mode_q;
  logic [3:0]  x_q;
  logic [3:0]  y_q;
  logic [7:0]  cnt_q;
  logic        in_a;
  logic        in_b;
  logic        in_c;
  logic        hit;
  logic        last;

  // Absolute differences avoid signed squaring; same result as (px-cx)^2.
  function automatic logic in_circle(
    input logic [3:0] px,
    input logic [3:0] py,
    input logic [3:0] cx,
    input logic [3:0] cy,
    input logic [3:0] r
  );
    logic [3:0] ax;
    logic [3:0] ay;
    logic [7:0] sx;
    logic [7:0] sy;
    logic [7:0] rr;
    logic [8:0] sum;
    ax  = (px >= cx) ? px - cx : cx - px;
    ay  = (py >= cy) ? py - cy : cy - py;
    sx  = {4'b0, ax} * {4'b0, ax};
    sy  = {4'b0, ay} * {4'b0, ay};
    rr  = {4'b0, r} * {4'b0, r};
    sum = {1'b0, sx} + {1'b0, sy};
    return sum <= {1'b0, rr};
  endfunction

  // Membership of the current point and the mode-selected predicate.
  always_comb begin
    in_a = in_circle(x_q, y_q, cen_q[23:20], cen_q[19:16], rad_q[11:8]);
    in_b = in_circle(x_q, y_q, cen_q[15:12], cen_q[11:8], rad_q[7:4]);
    in_c = in_circle(x_q, y_q, cen_q[7:4], cen_q[3:0], rad_q[3:0]);
    hit  = 1'b0;
    unique case (mode_q)
      2'b00: hit = in_a;
      2'b01: hit = in_a | in_b;
      2'b10: hit = in_a ^ in_b;
      2'b11: hit = in_a & in_b & in_c;
      default: hit = 1'b0;
    endcase
    last = (x_q == 4'd8) && (y_q == 4'd8);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    valid     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        valid     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, point scan and result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cen_q     <= '0;
      rad_q     <= '0;
      mode_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      candidate <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            cen_q  <= central;
            rad_q  <= radius;
            mode_q <= mode;
            x_q    <= 4'd1;
            y_q    <= 4'd1;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + {7'b0, hit};
          if (last) candidate <= cnt_q + {7'b0, hit};
          if (y_q == 4'd8) begin
            y_q <= 4'd1;
            x_q <= x_q + 4'd1;
          end else begin
            y_q <= y_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_candidate_counter.sv
// Directed bench for set_candidate_counter.
// Hand-computed counts; checks latency, strobe width and job latching.
module tb_set_candidate_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;

  int total = 0;
  int bad   = 0;

  logic [23:0] vc [8];
  logic [11:0] vr [8];
  logic [1:0]  vm [8];
  logic [7:0]  ve [8];

  always #5 clk = ~clk;

  set_candidate_counter dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .central  (central),
    .radius   (radius),
    .mode     (mode),
    .busy     (busy),
    .valid    (valid),
    .candidate(candidate)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    central = 24'hFFFFFF;
    radius  = 12'h000;
    mode    = 2'b11;
  endtask

  task automatic run_job(
    input string       name,
    input logic [23:0] c,
    input logic [11:0] r,
    input logic [1:0]  m,
    input logic [7:0]  exp
  );
    int k;
    bit seen;
    central = c;
    radius  = r;
    mode    = m;
    en      = 1'b1;
    step();
    en = 1'b0;
    scramble();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy: got %b want 1", name, busy);
    end
    k    = 0;
    seen = 0;
    while (!seen && k < 100) begin
      en = (k == 10);
      step();
      k++;
      if (valid === 1'b1) seen = 1;
    end
    en = 1'b0;
    total++;
    if (!seen || k != 64) begin
      bad++;
      $display("FAIL %s latency: got %0d seen=%0d want 64", name, k, seen);
    end
    total++;
    if (candidate !== exp) begin
      bad++;
      $display("FAIL %s count: got %0d want %0d", name, candidate, exp);
    end
    step();
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after: valid=%b busy=%b want 0 0", name, valid, busy);
    end
    total++;
    if (candidate !== exp) begin
      bad++;
      $display("FAIL %s hold: got %0d want %0d", name, candidate, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b0;
    scramble();
    repeat (3) step();
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || candidate !== 8'd0) begin
      bad++;
      $display("FAIL reset: busy=%b valid=%b cand=%0d want 0 0 0",
               busy, valid, candidate);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_mode_a();
    run_job("a_44_r2",  24'h44_0000, 12'h200, 2'b00, 8'd13);
    run_job("a_11_r1",  24'h11_0000, 12'h100, 2'b00, 8'd3);
    run_job("a_11_r15", 24'h11_0000, 12'hF00, 2'b00, 8'd64);
    run_job("a_11_r0",  24'h11_0000, 12'h000, 2'b00, 8'd1);
    run_job("a_00_r0",  24'h00_0000, 12'h000, 2'b00, 8'd0);
    run_job("a_00_r2",  24'h00_0000, 12'h200, 2'b00, 8'd1);
    run_job("a_ign_b",  24'h44_1100, 12'h2F0, 2'b00, 8'd13);
  endtask

  task automatic test_union_xor();
    run_job("union", 24'h22_77_00, 12'h110, 2'b01, 8'd10);
    run_job("xor",   24'h22_77_00, 12'h110, 2'b10, 8'd10);
    run_job("xor_eq", 24'h44_44_00, 12'h220, 2'b10, 8'd0);
  endtask

  task automatic test_intersect();
    run_job("and3", 24'h444444, 12'h222, 2'b11, 8'd13);
    run_job("and3_c0", 24'h444400, 12'h220, 2'b11, 8'd0);
  endtask

  task automatic test_abort();
    bit seen;
    central = 24'h44_0000;
    radius  = 12'h200;
    mode    = 2'b00;
    en      = 1'b1;
    step();
    en = 1'b0;
    repeat (20) step();
    rst = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || candidate !== 8'd0) begin
      bad++;
      $display("FAIL abort: busy=%b valid=%b cand=%0d want 0 0 0",
               busy, valid, candidate);
    end
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (valid === 1'b1) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_valid: got valid=1 want none");
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit seen;
    vc[0] = 24'h44_0000; vr[0] = 12'h200; vm[0] = 2'b00; ve[0] = 8'd13;
    vc[1] = 24'h11_0000; vr[1] = 12'h100; vm[1] = 2'b00; ve[1] = 8'd3;
    vc[2] = 24'h11_0000; vr[2] = 12'hF00; vm[2] = 2'b00; ve[2] = 8'd64;
    vc[3] = 24'h11_0000; vr[3] = 12'h000; vm[3] = 2'b00; ve[3] = 8'd1;
    vc[4] = 24'h22_7700; vr[4] = 12'h110; vm[4] = 2'b01; ve[4] = 8'd10;
    vc[5] = 24'h22_7700; vr[5] = 12'h110; vm[5] = 2'b10; ve[5] = 8'd10;
    vc[6] = 24'h44_4400; vr[6] = 12'h220; vm[6] = 2'b10; ve[6] = 8'd0;
    vc[7] = 24'h444444;  vr[7] = 12'h222; vm[7] = 2'b11; ve[7] = 8'd13;
    central = vc[0];
    radius  = vr[0];
    mode    = vm[0];
    en      = 1'b1;
    step();
    for (int j = 0; j < 64; j++) begin
      scramble();
      k    = 0;
      seen = 0;
      while (!seen && k < 100) begin
        step();
        k++;
        if (valid === 1'b1) seen = 1;
      end
      total++;
      if (!seen || k != 64) begin
        bad++;
        $display("FAIL b2b_lat job %0d: got %0d seen=%0d want 64", j, k, seen);
      end
      total++;
      if (candidate !== ve[j % 8]) begin
        bad++;
        $display("FAIL b2b_count job %0d: got %0d want %0d",
                 j, candidate, ve[j % 8]);
      end
      if (j < 63) begin
        central = vc[(j + 1) % 8];
        radius  = vr[(j + 1) % 8];
        mode    = vm[(j + 1) % 8];
        step();
        total++;
        if (valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_strobe job %0d: got valid=%b want 0", j, valid);
        end
        step();
      end
    end
    en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_mode_a();
    test_union_xor();
    test_intersect();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
